div_restoring: RTL and testbench
================================

# div_restoring

Sequential restoring shift-subtract divider, the inverse of the team's shift-add multiplier. It divides an N-bit dividend by an N-bit divisor, one quotient bit per clock, with a start/done handshake. It sits next to the multiplier in the arithmetic unit and shares the same operand and result conventions.

## Interface
- N, 32, operand width (N ≥ 2); quotient and remainder are N bits each
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a division; sampled only in IDLE
- dividend_in  in  N  dividend; captured in the cycle start is accepted
- divisor_in  in  N  divisor; captured in the cycle start is accepted
- busy  out  1  high whenever the state is not IDLE
- done  out  1  single-cycle pulse; results are valid from this cycle on
- quotient_out  out  N  quotient; held until the next accepted start
- remainder_out  out  N  remainder; held until the next accepted start
- div_by_zero  out  1  set with done when the captured divisor was 0; held with the results

## Operation
- States: IDLE, CALC, DONE. Encoding is binary, from the shared package.
- IDLE, start=1, divisor_in≠0:
  - load R (N+1 bits) ← 0, Q ← dividend_in, D ← divisor_in
  - load the counter with N; clear div_by_zero; go to CALC
- IDLE, start=1, divisor_in=0:
  - Q ← all ones, R ← dividend_in, div_by_zero ← 1; go to DONE
- CALC iteration, in one cycle:
  - shift {R,Q} left by 1
  - compute T = R_shifted − {1'b0,D} at N+1 bits
  - if there is no borrow (T[N]=0): R ← T, Q[0] ← 1
  - otherwise R keeps its shifted value and Q[0] ← 0
  - decrement the counter
  - when the counter goes from 1 to 0, go to DONE
- DONE: done=1 for exactly one cycle, then IDLE. quotient_out = Q; remainder_out = R[N-1:0].
- A start while busy=1, including in the DONE cycle, is ignored with no side effects.
- Operands may change freely after the capture cycle.
- R never exceeds D, so N+1 bits are enough. Q is exact, with no truncation.

## Timing
- Reset values: state=IDLE, busy=0, done=0, div_by_zero=0, quotient_out=0, remainder_out=0, counter=0.
- Normal latency: start is accepted at edge 0. There are N CALC cycles. done is high in cycle N+1 (cycle 33 for N=32).
- Divide by zero: done is high in cycle 1.
- Back-to-back: the earliest next start is accepted in the cycle after done, which is IDLE. That gives a throughput of one division per N+2 cycles.
- rst mid-operation: all state returns to the reset values on the next edge. The partial result is discarded and no done is produced.
- All outputs are registered. There is no combinational path from the inputs to the outputs.

## Configuration
- DIV_SIGNED_EN defined: operands are two's-complement.
  - At capture, Q ← |dividend| and D ← |divisor|; the signs are registered.
  - On the CALC→DONE transition, the quotient is negated if the signs differ, and the remainder takes the dividend's sign.
  - Latency is unchanged.
  - Overflow (−2^(N−1) / −1) gives quotient = −2^(N−1) and remainder = 0.
  - Divide by zero gives quotient = −1 (all ones) and remainder = dividend, with div_by_zero=1.
- DIV_SIGNED_EN not defined: all operands are unsigned and the sign logic is absent.

## Structure
- Package div_pkg holds the state enum typedef (IDLE, CALC, DONE) and the counter-width function/constant CNT_W = $clog2(N+1).
- One natural sub-module, div_datapath, holds:
  - the R/Q/D registers
  - the (N+1)-bit subtractor with borrow out
  - the iteration counter
- The top level holds the FSM and drives the datapath's control strobes: load, step, finish.

## Test plan
- 100 / 7 → at cycle 33: done=1, quotient=14, remainder=2, div_by_zero=0. busy is high in cycles 1–33.
- 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0. Also 3 / 10 → quotient=0, remainder=3.
- 5 / 0 → at cycle 1: done=1, div_by_zero=1, quotient=0xFFFFFFFF, remainder=5. The next valid divide clears div_by_zero.
- Start 1000 / 3, pulse start with 9 / 9 at cycle 5 and at the DONE cycle → both ignored. Result: quotient=333, remainder=1.
- Start 1000 / 3, assert rst at cycle 10 → busy=0, done never pulses, all outputs 0. Then 50 / 5 → quotient=10, remainder=0 at cycle N+1.
- With DIV_SIGNED_EN:
  - −7 / 2 → quotient=−3, remainder=−1
  - 7 / −2 → quotient=−3, remainder=1
  - 0x80000000 / −1 → quotient=0x80000000, remainder=0

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the restoring divider.
// Holds the FSM state encoding and the iteration-counter width helper.
package div_pkg;

  // Binary-encoded controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold the value N, so it needs clog2(N+1) bits.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Default operand width of the arithmetic unit and its counter width.
  localparam int DIV_N = 32;
  localparam int CNT_W = cnt_width(DIV_N);

endpackage

// File: rtl/div_datapath.sv
// div_datapath: R/Q/D registers, (N+1)-bit trial subtractor, iteration
// counter and the held result registers of the restoring divider.
// Optional feature macro: DIV_SIGNED_EN (two's-complement operands).
module div_datapath
  import div_pkg::*;
#(
  parameter int N  = DIV_N,
  parameter int CW = cnt_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         load_zero_i,
  input  logic         step_i,
  input  logic         finish_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         last_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic         div_by_zero_o
);

  logic [N:0]    r_q;
  logic [N-1:0]  q_q;
  logic [N-1:0]  d_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  quot_q;
  logic [N-1:0]  rem_q;
  logic          dbz_q;

  logic [N+1:0]  r_wide;
  logic [N+1:0]  t_wide;
  logic          borrow;
  logic [N:0]    r_d;
  logic [N-1:0]  q_d;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic [N-1:0]  q_fin;
  logic [N-1:0]  r_fin;

`ifdef DIV_SIGNED_EN
  logic neg_q_q;
  logic neg_r_q;

  // Magnitudes go into the unsigned core; signs are re-applied at finish.
  always_comb begin
    op_a  = dividend_i[N-1] ? -dividend_i : dividend_i;
    op_b  = divisor_i[N-1]  ? -divisor_i  : divisor_i;
    q_fin = neg_q_q ? -q_d : q_d;
    r_fin = neg_r_q ? -r_d[N-1:0] : r_d[N-1:0];
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    op_a  = dividend_i;
    op_b  = divisor_i;
    q_fin = q_d;
    r_fin = r_d[N-1:0];
  end
`endif

  // One restoring iteration: shift {R,Q} left, trial-subtract D, keep or restore.
  // R is always below D, so its top bit is zero and the extra guard bit of
  // r_wide never changes the outcome; it only keeps the borrow a plain MSB.
  always_comb begin
    r_wide = {r_q, q_q[N-1]};
    t_wide = r_wide - {2'b00, d_q};
    borrow = t_wide[N+1];
    r_d    = borrow ? r_wide[N:0] : t_wide[N:0];
    q_d    = {q_q[N-2:0], ~borrow};
  end

  assign last_o        = (cnt_q == CW'(1));
  assign quotient_o    = quot_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;

  // Working registers, counter and held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else if (load_i) begin
      r_q   <= '0;
      q_q   <= op_a;
      d_q   <= op_b;
      cnt_q <= CW'(N);
      dbz_q <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_q <= dividend_i[N-1] ^ divisor_i[N-1];
      neg_r_q <= dividend_i[N-1];
`endif
    end else if (load_zero_i) begin
      // Divide by zero: all-ones quotient, dividend returned as remainder.
      q_q    <= '1;
      r_q    <= {1'b0, dividend_i};
      quot_q <= '1;
      rem_q  <= dividend_i;
      dbz_q  <= 1'b1;
    end else if (step_i) begin
      r_q   <= r_d;
      q_q   <= q_d;
      cnt_q <= cnt_q - CW'(1);
      if (finish_i) begin
        quot_q <= q_fin;
        rem_q  <= r_fin;
      end
    end
  end

endmodule

// File: rtl/div_restoring.sv
// div_restoring: sequential restoring divider, one quotient bit per clock,
// start/done handshake. Optional feature macro: DIV_SIGNED_EN.
module div_restoring
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend_in,
  input  logic [N-1:0] divisor_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient_out,
  output logic [N-1:0] remainder_out,
  output logic         div_by_zero
);

  state_e state_q;
  logic   busy_q;
  logic   done_q;
  logic   last;
  logic   divisor_zero;
  logic   load;
  logic   load_zero;
  logic   step;
  logic   finish;

  assign divisor_zero = (divisor_in == '0);

  // Datapath strobes; a start outside IDLE produces none of them.
  always_comb begin
    load      = (state_q == IDLE) && start && !divisor_zero;
    load_zero = (state_q == IDLE) && start && divisor_zero;
    step      = (state_q == CALC);
    finish    = (state_q == CALC) && last;
  end

  // Controller FSM with registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (divisor_zero) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  div_datapath #(
    .N (N)
  ) u_datapath (
    .clk           (clk),
    .rst           (rst),
    .load_i        (load),
    .load_zero_i   (load_zero),
    .step_i        (step),
    .finish_i      (finish),
    .dividend_i    (dividend_in),
    .divisor_i     (divisor_in),
    .last_o        (last),
    .quotient_o    (quotient_out),
    .remainder_o   (remainder_out),
    .div_by_zero_o (div_by_zero)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_div_restoring.sv
// tb_div_restoring: directed-vector bench for div_restoring (N=32).
// Signed vectors are added when DIV_SIGNED_EN is defined.
module tb_div_restoring;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend_in;
  logic [31:0] divisor_in;
  logic        busy;
  logic        done;
  logic [31:0] quotient_out;
  logic [31:0] remainder_out;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_restoring #(.N(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .dividend_in   (dividend_in),
    .divisor_in    (divisor_in),
    .busy          (busy),
    .done          (done),
    .quotient_out  (quotient_out),
    .remainder_out (remainder_out),
    .div_by_zero   (div_by_zero)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, act);
    end
  endtask

  // Called at a negedge; the following posedge is edge 0 (accept).
  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    dividend_in = a;
    divisor_in  = b;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    dividend_in = 32'hA5A5_5A5A;
    divisor_in  = 32'h0000_0003;
  endtask

  // Counts cycles after edge 0 until done; busy must be high throughout.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy !== 1'b1) begin
        check_eq({tag, " busy"}, {31'd0, busy}, 32'd1);
      end
    end while (!done && cyc < 100);
    check_eq({tag, " done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int ecyc);
    int cyc;
    do_start(a, b);
    wait_done(tag, cyc);
    check_eq({tag, " cycle"}, cyc, ecyc);
    check_eq({tag, " quot"}, quotient_out, eq);
    check_eq({tag, " rem"}, remainder_out, er);
    check_eq({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, edz});
    @(negedge clk);
    check_eq({tag, " done pulse"}, {31'd0, done}, 32'd0);
    check_eq({tag, " idle busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    rst         = 1'b1;
    start       = 1'b0;
    dividend_in = '0;
    divisor_in  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset busy", {31'd0, busy}, 32'd0);
    check_eq("reset done", {31'd0, done}, 32'd0);
    check_eq("reset quot", quotient_out, 32'd0);
    check_eq("reset rem", remainder_out, 32'd0);
    check_eq("reset dbz", {31'd0, div_by_zero}, 32'd0);

    // Basic vectors.
    run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    run_div("3/10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33);
    run_div("msb/16", 32'h8000_0000, 32'd16, 32'h0800_0000, 32'd0, 1'b0, 33);

    // Divide by zero, then a valid divide clears the flag.
    run_div("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    run_div("12345/100", 32'd12345, 32'd100, 32'd123, 32'd45, 1'b0, 33);

    // Starts while busy (mid-CALC and in DONE) are ignored.
    do_start(32'd1000, 32'd3);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        dividend_in = 32'd9;
        divisor_in  = 32'd9;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end while (!done && cyc < 100);
    check_eq("ign done", {31'd0, done}, 32'd1);
    check_eq("ign cycle", cyc, 33);
    check_eq("ign quot", quotient_out, 32'd333);
    check_eq("ign rem", remainder_out, 32'd1);
    dividend_in = 32'd9;
    divisor_in  = 32'd9;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check_eq("ign done-cycle start busy", {31'd0, busy}, 32'd0);
    check_eq("ign hold quot", quotient_out, 32'd333);

    // Reset in the middle of an operation.
    do_start(32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst busy", {31'd0, busy}, 32'd0);
    check_eq("rst quot", quotient_out, 32'd0);
    check_eq("rst rem", remainder_out, 32'd0);
    check_eq("rst dbz", {31'd0, div_by_zero}, 32'd0);
    cyc = 0;
    repeat (40) begin
      if (done) cyc++;
      @(negedge clk);
    end
    check_eq("rst no done", cyc, 0);
    run_div("50/5", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);

`ifdef DIV_SIGNED_EN
    run_div("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_div("7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    run_div("-9/0", 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "time limit reached");
  end

endmodule
